uart_driver: RTL and testbench
==============================

# uart_driver

Testbench-side UART transmitter that drives the serial line decoded by the simulation UART monitor, and also serves as stimulus for the core's UART receive pin. Bytes arrive over a valid/ready handshake and are buffered in a small FIFO. Each byte is serialized as an 8N1 frame, LSB first, with a fixed clock-per-bit divisor. Back-to-back frames are emitted with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 1798: clock cycles per serial bit; legal range is ≥ 2.
- `FIFO_AW`, default 2: FIFO address width; depth is 2^FIFO_AW entries.
- `clk_i`  in  1: single clock; all logic is sampled on the rising edge.
- `rst_ni`  in  1: reset, asynchronous and active-low.
- `data_i`  in  8: byte to transmit.
- `valid_i`  in  1: `data_i` is valid.
- `ready_o`  out  1: FIFO can accept; a push occurs on an edge where `valid_i & ready_o`.
- `uart_tx_o`  out  1: serial line; registered; idle level is 1.
- `busy_o`  out  1: the FSM is not IDLE, or the FIFO is non-empty.
- `fifo_cnt_o`  out  FIFO_AW+1: current FIFO occupancy, range 0..2^FIFO_AW.

## Operation
- **Reset (async):**
  - `uart_tx_o` = 1.
  - FIFO is emptied: `fifo_cnt_o` = 0, read and write pointers = 0.
  - FSM = IDLE; bit and baud counters are cleared.
  - Resulting outputs: `ready_o` = 1, `busy_o` = 0.
  - Reset mid-frame aborts the frame immediately; the line returns high and there is no stop bit and no resume.
- **FIFO:**
  - Circular buffer with FIFO_AW-bit pointers that wrap modulo the depth.
  - `ready_o` = (`fifo_cnt_o` != depth); it is combinational from the count.
  - A push and a pop on the same edge leave the count unchanged; when the FIFO is full, `ready_o` = 0, so no push occurs that edge.
- **FSM states:**
  - IDLE, START, DATA, STOP.
  - Baud counter `bcnt` is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1. `tick` = (`bcnt` == CLKS_PER_BIT-1).
  - Bit index is 3 bits wide; the shift register is 8 bits wide.
- **Transitions:**
  - **IDLE → START:** when the FIFO is non-empty. On that edge: pop the head into the shift register, set `uart_tx_o` ← 0, set `bcnt` ← 0.
  - **START → DATA:** on `tick`. Set `uart_tx_o` ← shift[0], bit index ← 0, `bcnt` ← 0.
  - **DATA, on `tick` with index < 7:** shift right, drive the next bit, increment the index.
  - **DATA → STOP:** on `tick` with index == 7. Set `uart_tx_o` ← 1.
  - **STOP → START:** on `tick` when the FIFO is non-empty. Pop and drive 0 on the same edge, so there is no gap.
  - **STOP → IDLE:** on `tick` when the FIFO is empty; the line stays 1.
- `valid_i` held while `ready_o` = 0: the byte is not consumed and not lost; it is pushed on the first edge where `ready_o` = 1.
- `data_i` is sampled only on the push edge; later changes do not affect the queued byte.

## Timing
- **Latency:** a push at edge k into an empty FIFO in IDLE gives `fifo_cnt_o` = 1 after k, and `uart_tx_o` falls at edge k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles (start, 8 data, stop).
  - Each bit level holds for exactly CLKS_PER_BIT cycles.
- **Back-to-back:** consecutive frames start exactly 10·CLKS_PER_BIT cycles apart while the FIFO stays non-empty.
- **Throughput:** one push per cycle until full; one pop per frame.
- **`busy_o`:**
  - Rises the cycle after the first push.
  - Falls on the edge where the final STOP `tick` returns the FSM to IDLE with the FIFO empty.
- **`ready_o` after a pop from full:** reasserts in the cycle following the pop edge.

## Test plan
- **Single byte:** CLKS_PER_BIT=16; push 0x55 at edge k.
  - Line falls at k+1.
  - Line then carries 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each level exactly 16 cycles.
  - `busy_o` clears at k+161.
- **Fill and stall:** FIFO_AW=2; hold `valid_i` with 0x10..0x15 every cycle.
  - Push 0x10 is popped at the next edge.
  - 0x11–0x14 fill the FIFO; `ready_o` = 0 while 0x15 waits.
  - 0x15 is accepted the cycle after the second pop.
  - Six frames go out in order, gap-free, 160 cycles apart.
- **Loopback:** CLKS_PER_BIT=1798; connect `uart_tx_o` to the UART monitor and send 'A','B','\n'.
  - Monitor shift register shows 0x41, 0x42, 0x0A in order.
- **Reset mid-frame:** assert `rst_ni` = 0 during DATA bit 3 of 0xA5 with two bytes queued.
  - `uart_tx_o` = 1 immediately (asynchronously).
  - `fifo_cnt_o` = 0.
  - After release, the line stays idle with no residual frame.
- **Simultaneous push/pop:** FIFO holds 2 entries; push 0x7E on the STOP→START pop edge.
  - `fifo_cnt_o` stays at 2.
  - Byte order is preserved.
- **Wrap-around:** push 9 bytes 0x00..0x08 with FIFO_AW=2.
  - Pointers wrap twice.
  - Serialized order is 0x00..0x08 with no duplication.

Source files
------------

// File: rtl/uart_driver.sv
// uart_driver: valid/ready byte FIFO feeding an 8N1 serializer (LSB first),
// emitting back-to-back frames with no idle gap between them.
module uart_driver #(
  parameter int unsigned CLKS_PER_BIT = 1798,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic [FIFO_AW:0] fifo_cnt_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         r_state;
  logic [BW-1:0]      r_bcnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CW-1:0]      r_cnt;

  logic w_tick;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_tick  = (r_bcnt == BW'(CLKS_PER_BIT - 1));
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_push  = valid_i & ~w_full;
  // The head is consumed either from IDLE or on the final STOP tick so the
  // next start bit begins on the very edge the current stop bit ends.
  assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_tick));

  assign ready_o    = ~w_full;
  assign busy_o     = (r_state != S_IDLE) | ~w_empty;
  assign fifo_cnt_o = r_cnt;
  assign uart_tx_o  = r_tx;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bcnt <= '0;
          if (!w_empty) begin
            r_state <= S_START;
            r_shift <= r_mem[r_rptr];
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_bcnt    <= '0;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_bcnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: begin
          if (w_tick) begin
            r_bcnt <= '0;
            if (!w_empty) begin
              r_state <= S_START;
              r_shift <= r_mem[r_rptr];
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_driver.sv
// Randomized scoreboard bench for uart_driver: a schedule-level line/FIFO model
// plus a UART receiver that decodes frames and checks them against accepted bytes.
module tb_uart_driver;

  localparam int unsigned N     = 16;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic          tx;
  logic          busy;
  logic [AW:0]   cnt;

  uart_driver #(.CLKS_PER_BIT(N), .FIFO_AW(AW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data),
    .valid_i    (valid),
    .ready_o    (ready),
    .uart_tx_o  (tx),
    .busy_o     (busy),
    .fifo_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, line state as the edge index
  // where the current frame started.
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  int unsigned cyc = 0;
  bit          m_active = 0;
  int unsigned m_start = 0;
  logic [7:0]  m_byte = '0;
  bit          m_acc = 0;
  bit          do_pop;
  bit          do_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_active = 0;
      m_acc    = 0;
    end else begin
      cyc++;
      do_pop = 0;
      if (!m_active) begin
        do_pop = (mq.size() != 0);
      end else if (cyc == m_start + 10 * N) begin
        if (mq.size() != 0) do_pop = 1;
        else m_active = 0;
      end
      do_push = valid && (mq.size() < DEPTH);
      if (do_pop) begin
        m_byte   = mq.pop_front();
        m_active = 1;
        m_start  = cyc;
      end
      if (do_push) begin
        mq.push_back(data);
        exp_q.push_back(data);
      end
      m_acc = do_push;
    end
  end

  // Per-cycle comparison of every output against the model.
  int unsigned off;
  int unsigned bidx;
  logic        exp_tx;
  always @(negedge clk) begin
    exp_tx = 1'b1;
    if (rst_n && m_active) begin
      off  = cyc - m_start;
      bidx = off / N;
      if (bidx == 0) exp_tx = 1'b0;
      else if (bidx <= 8) exp_tx = m_byte[bidx-1];
    end
    check("tx_line", {31'd0, tx}, {31'd0, exp_tx});
    check("ready", {31'd0, ready}, {31'd0, (mq.size() != DEPTH)});
    check("busy", {31'd0, busy}, {31'd0, (m_active || mq.size() != 0)});
    check("fifo_cnt", {29'd0, cnt}, mq.size());
  end

  // Receiver: detects the start edge, samples mid-bit, pops the scoreboard.
  bit          rx_active = 0;
  int unsigned rx_cnt = 0;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  rx_exp;
  int unsigned k;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % N == N / 2) begin
        k = rx_cnt / N;
        if (k >= 1 && k <= 8) begin
          rx_byte[k-1] = tx;
        end else if (k == 9) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
          end else begin
            rx_exp = exp_q.pop_front();
            check("sb_frame_byte", {24'd0, rx_byte}, {24'd0, rx_exp});
          end
          rx_active = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int unsigned guard = 0;
    valid = 1'b1;
    data  = b;
    forever begin
      @(posedge clk);
      #1;
      if (m_acc) break;
      guard++;
      if (guard > 5000) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    while (m_active || mq.size() != 0) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        check("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int unsigned target);
    int unsigned guard = 0;
    while (cyc != target) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        check("cycle_wait_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cnt", {29'd0, cnt}, 32'd0);

    send(8'h55);
    wait_idle();

    for (int unsigned i = 0; i < 6; i++) send(8'(8'h10 + i));
    wait_idle();

    for (int unsigned i = 0; i < 9; i++) send(8'(i));
    wait_idle();

    // Push lands on the STOP->START pop edge while two bytes wait.
    send(8'h31);
    send(8'h32);
    send(8'h33);
    wait_cycle(m_start + 10 * N - 1);
    valid = 1'b1;
    data  = 8'h7E;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("pushpop_accepted", {31'd0, m_acc}, 32'd1);
    check("pushpop_cnt", {29'd0, cnt}, 32'd2);
    wait_idle();

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    send(8'hA5);
    send(8'h3C);
    send(8'hC3);
    wait_cycle(m_start + 4 * N + 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_cnt", {29'd0, cnt}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12 * N) @(posedge clk);
    #1;
    check("postreset_tx", {31'd0, tx}, 32'd1);

    for (int unsigned i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3 * N)) @(posedge clk);
      #1;
      send(8'($urandom));
    end
    wait_idle();

    check("sb_drained", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
